stim_gen: RTL

STIM_GEN -- requirements
Module: stim_gen

---
 rtl/stim_gen_pkg.sv | 18 +
 rtl/stim_pattern.sv | 21 ++
 rtl/stim_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the stimulus generator.
package stim_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Taps d[7], d[5], d[4], d[3] of the 8-bit Fibonacci LFSR
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_SEED  = 8'hA5;

  function automatic logic lfsr_fb(input logic [7:0] d);
    return ^(d & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/stim_pattern.sv
// Next-value generator: 8-bit left-shifting LFSR when STIM_GEN_LFSR_EN is
// defined, otherwise a wrapping incrementer.
module stim_pattern
  import stim_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_cur,
  output logic [DATA_WIDTH-1:0] o_next
);

`ifdef STIM_GEN_LFSR_EN
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("stim_pattern: LFSR mode requires DATA_WIDTH == 8");
  end
  assign o_next = {i_cur[6:0], lfsr_fb(i_cur[7:0])};
`else
  assign o_next = i_cur + DATA_WIDTH'(1);
`endif

endmodule

// File: rtl/stim_gen.sv
// Stimulus generator: emits NUM_ITEMS items per run over a valid/ready link and
// a one-cycle-delayed expected response (inverted item). LFSR mode: STIM_GEN_LFSR_EN.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_ITEMS  = 16,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(DEF_SEED)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  exp_valid,
  output logic [DATA_WIDTH-1:0] exp_data,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            sent_cnt
);

`ifdef STIM_GEN_LFSR_EN
  // An all-zero LFSR state would lock up, so substitute 1
  localparam logic [DATA_WIDTH-1:0] LOAD_SEED = (SEED == '0) ? DATA_WIDTH'(1) : SEED;
`else
  localparam logic [DATA_WIDTH-1:0] LOAD_SEED = SEED;
`endif

  state_e                  r_state, w_state_nxt;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_exp_valid;
  logic [DATA_WIDTH-1:0]   r_exp_data;
  logic [7:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   w_next;
  logic                    w_hs;
  logic                    w_last;
  logic                    w_load;
  logic                    w_busy;
  logic                    w_done;

  stim_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .i_cur  (r_data),
    .o_next (w_next)
  );

  assign w_hs   = r_valid & ready;
  assign w_last = (r_cnt + 8'd1) == 8'(NUM_ITEMS);
  assign w_load = (r_state == ST_IDLE) & start;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_hs && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_exp_valid <= 1'b0;
      r_exp_data  <= '0;
    end else begin
      r_exp_valid <= w_hs;
      if (w_hs) r_exp_data <= ~r_data;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= LOAD_SEED;
        r_cnt   <= '0;
      end else if (w_hs) begin
        r_data <= w_next;
        r_cnt  <= r_cnt + 8'd1;
        if (w_last) r_valid <= 1'b0;
      end
    end
  end

  assign valid     = r_valid;
  assign data_out  = r_data;
  assign exp_valid = r_exp_valid;
  assign exp_data  = r_exp_data;
  assign busy      = w_busy;
  assign done      = w_done;
  assign sent_cnt  = r_cnt;

endmodule
